// File: rtl/microblaze_bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port B between two single-word requesters.
// Each transaction walks IDLE -> ACCESS -> CAPTURE -> ACK. Every output is a
// register, so no input reaches an output through combinational logic.
module microblaze_bram_port_arbiter #(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_MEMSIZE     = 32'h0000_2000,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_PORT_AWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst,
    input  logic                     REQ0_Req,
    input  logic [0:C_NUM_WE-1]      REQ0_WE,
    input  logic [0:C_PORT_AWIDTH-1] REQ0_Addr,
    input  logic [0:C_PORT_DWIDTH-1] REQ0_WrData,
    output logic [0:C_PORT_DWIDTH-1] REQ0_RdData,
    output logic                     REQ0_Ack,
    output logic                     REQ0_Err,
    input  logic                     REQ1_Req,
    input  logic [0:C_NUM_WE-1]      REQ1_WE,
    input  logic [0:C_PORT_AWIDTH-1] REQ1_Addr,
    input  logic [0:C_PORT_DWIDTH-1] REQ1_WrData,
    output logic [0:C_PORT_DWIDTH-1] REQ1_RdData,
    output logic                     REQ1_Ack,
    output logic                     REQ1_Err,
    output logic                     BRAM_EN,
    output logic [0:C_NUM_WE-1]      BRAM_WEN,
    output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;       // requester favoured when both ask at once
    logic   grant_q, grant_d;   // requester owning the current transaction
    logic   err_q, err_d;       // current transaction is out of range
    logic [0:C_NUM_WE-1] we_q, we_d;

    logic                     en_d;
    logic [0:C_NUM_WE-1]      wen_d;
    logic [0:C_PORT_AWIDTH-1] addr_d;
    logic [0:C_PORT_DWIDTH-1] dout_d;
    logic                     ack0_d, err0_d, ack1_d, err1_d;
    logic [0:C_PORT_DWIDTH-1] rd0_d, rd1_d;

    // Arbitration: a lone request always wins; the pointer only breaks ties.
    logic                     pick;
    logic [0:C_NUM_WE-1]      sel_we;
    logic [0:C_PORT_AWIDTH-1] sel_addr;
    logic [0:C_PORT_DWIDTH-1] sel_wrdata;
    logic [0:C_PORT_AWIDTH-1] sel_offset;
    logic                     in_range;
    logic [0:C_PORT_DWIDTH-1] capture_data;

    assign pick       = REQ1_Req & (~REQ0_Req | ptr_q);
    assign sel_we     = pick ? REQ1_WE     : REQ0_WE;
    assign sel_addr   = pick ? REQ1_Addr   : REQ0_Addr;
    assign sel_wrdata = pick ? REQ1_WrData : REQ0_WrData;

    // Unsigned wrap-around makes addresses below the base look huge, so a
    // single compare rejects both ends of the window.
    assign sel_offset = sel_addr - C_BASEADDR;
    assign in_range   = sel_offset < C_MEMSIZE;

    // Writes and rejected accesses return zero instead of stale port data.
    assign capture_data = (err_q || (we_q != '0)) ? '0 : BRAM_Din;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        err_d   = err_q;
        we_d    = we_q;
        en_d    = 1'b0;
        wen_d   = '0;
        addr_d  = '0;
        dout_d  = '0;
        ack0_d  = 1'b0;
        err0_d  = 1'b0;
        rd0_d   = '0;
        ack1_d  = 1'b0;
        err1_d  = 1'b0;
        rd1_d   = '0;
        case (state_q)
            IDLE: begin
                if (REQ0_Req || REQ1_Req) begin
                    state_d = ACCESS;
                    grant_d = pick;
                    ptr_d   = ~pick;
                    we_d    = sel_we;
                    err_d   = ~in_range;
                    if (in_range) begin
                        en_d   = 1'b1;
                        wen_d  = sel_we;
                        addr_d = {sel_addr[0:C_PORT_AWIDTH-3], 2'b00};
                        dout_d = sel_wrdata;
                    end
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: begin
                state_d = ACK;
                if (grant_q) begin
                    ack1_d = 1'b1;
                    err1_d = err_q;
                    rd1_d  = capture_data;
                end else begin
                    ack0_d = 1'b1;
                    err0_d = err_q;
                    rd0_d  = capture_data;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, round-robin pointer and per-transaction context.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values, like real flops.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    // Registered BRAM port and requester response outputs.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            BRAM_EN     <= 1'b0;
            BRAM_WEN    <= '0;
            BRAM_Addr   <= '0;
            BRAM_Dout   <= '0;
            REQ0_Ack    <= 1'b0;
            REQ0_Err    <= 1'b0;
            REQ0_RdData <= '0;
            REQ1_Ack    <= 1'b0;
            REQ1_Err    <= 1'b0;
            REQ1_RdData <= '0;
        end else begin
            BRAM_EN     <= en_d;
            BRAM_WEN    <= wen_d;
            BRAM_Addr   <= addr_d;
            BRAM_Dout   <= dout_d;
            REQ0_Ack    <= ack0_d;
            REQ0_Err    <= err0_d;
            REQ0_RdData <= rd0_d;
            REQ1_Ack    <= ack1_d;
            REQ1_Err    <= err1_d;
            REQ1_RdData <= rd1_d;
        end
    end

endmodule

// File: tb/tb_microblaze_bram_port_arbiter.sv
// Directed bench for the BRAM port arbiter: a vector table of single
// transactions, then contention, reset-pointer and mid-transaction reset cases.
`timescale 1ns/1ps
module tb_microblaze_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [0:3]  we0 = '0, we1 = '0;
    logic [0:31] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [0:31] rd0, rd1;
    logic        ack0, ack1, err0, err1;
    logic        en;
    logic [0:3]  wen;
    logic [0:31] baddr, dout;
    logic [0:31] din = '0;

    logic [0:31] mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    // Result of the most recent transaction, filled in by wait_ack.
    int          r_lat, r_en, r_other;
    logic [0:31] r_rd, r_ord, r_addr, r_dout;
    logic [0:3]  r_wen;
    logic        r_err;

    always #5 clk = ~clk;

    microblaze_bram_port_arbiter dut (
        .BRAM_Clk   (clk),
        .BRAM_Rst   (rst),
        .REQ0_Req   (req0),
        .REQ0_WE    (we0),
        .REQ0_Addr  (addr0),
        .REQ0_WrData(wd0),
        .REQ0_RdData(rd0),
        .REQ0_Ack   (ack0),
        .REQ0_Err   (err0),
        .REQ1_Req   (req1),
        .REQ1_WE    (we1),
        .REQ1_Addr  (addr1),
        .REQ1_WrData(wd1),
        .REQ1_RdData(rd1),
        .REQ1_Ack   (ack1),
        .REQ1_Err   (err1),
        .BRAM_EN    (en),
        .BRAM_WEN   (wen),
        .BRAM_Addr  (baddr),
        .BRAM_Dout  (dout),
        .BRAM_Din   (din)
    );

    // 8 KiB BRAM model: byte writes, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) mem[baddr[19:29]][8*b +: 8] <= dout[8*b +: 8];
            din <= mem[baddr[19:29]];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {30'd0, ack0, ack1}, 32'd0);
        check({tag, "_err"}, {30'd0, err0, err1}, 32'd0);
        check({tag, "_rd0"}, rd0, 32'd0);
        check({tag, "_rd1"}, rd1, 32'd0);
        check({tag, "_en_wen"}, {27'd0, en, wen}, 32'd0);
        check({tag, "_baddr"}, baddr, 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
    endtask

    // Waits (bounded) for the Ack of requester 'who', recording what the port did.
    task automatic wait_ack(input int who);
        r_lat = 0; r_en = 0; r_other = 0; r_err = 1'b0;
        r_rd = '0; r_ord = '0; r_addr = '0; r_dout = '0; r_wen = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (en) begin
                r_en++;
                r_addr = baddr;
                r_wen  = wen;
                r_dout = dout;
            end
            if ((who == 0) ? ack1 : ack0) r_other++;
            if ((who == 0) ? ack0 : ack1) begin
                r_lat = c;
                r_rd  = (who == 0) ? rd0 : rd1;
                r_ord = (who == 0) ? rd1 : rd0;
                r_err = (who == 0) ? err0 : err1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (who == 0) begin req0 = 1'b0; we0 = '0; addr0 = '0; wd0 = '0; end
        else          begin req1 = 1'b0; we1 = '0; addr1 = '0; wd1 = '0; end
    endtask

    task automatic run_txn(input int who, input logic [0:3] we, input logic [0:31] addr,
                           input logic [0:31] wd);
        @(negedge clk);
        if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wd0 = wd; end
        else          begin req1 = 1'b1; we1 = we; addr1 = addr; wd1 = wd; end
        wait_ack(who);
    endtask

    // Both requesters issue reads back to back; grants must alternate from 'first'.
    task automatic contend(input string tag, input int first, input int n);
        int got    = 0;
        int last_c = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = '0; addr0 = 32'h0000_0010;
        req1 = 1'b1; we1 = '0; addr1 = 32'h0000_0020;
        for (int c = 1; c <= 4 * n + 8 && got < n; c++) begin
            @(negedge clk);
            check({tag, "_excl"}, {31'd0, ack0 & ack1}, 32'd0);
            if (ack0 || ack1) begin
                check({tag, "_who"}, {31'd0, ack1}, (first + got) % 2);
                check({tag, "_gap"}, c - last_c, (got == 0) ? 3 : 4);
                check({tag, "_rd"}, ack1 ? rd1 : rd0, ack1 ? 32'h11BB_3344 : 32'hDEAD_BEEF);
                last_c = c;
                got++;
            end
        end
        check({tag, "_count"}, got, n);
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    endtask

    typedef struct {
        string       name;
        int          who;
        logic [0:3]  we;
        logic [0:31] addr;
        logic [0:31] wd;
        logic [0:31] exp_rd;
        logic        exp_err;
        logic [0:31] exp_baddr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"wr_dead",    0, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0, 32'h0000_0010};
        vecs[1] = '{"lone_rd",    0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0010};
        vecs[2] = '{"wr_full",    0, 4'hF,    32'h0000_0020, 32'h1122_3344, 32'h0,          1'b0, 32'h0000_0020};
        vecs[3] = '{"wr_byte1",   0, 4'b0100, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,          1'b0, 32'h0000_0020};
        vecs[4] = '{"rd_merged",  1, 4'h0,    32'h0000_0020, 32'h0,         32'h11BB_3344, 1'b0, 32'h0000_0020};
        vecs[5] = '{"rd_unalign", 1, 4'h0,    32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0010};
        vecs[6] = '{"wr_top",     1, 4'hF,    32'h0000_1FFC, 32'h5A5A_A5A5, 32'h0,          1'b0, 32'h0000_1FFC};
        vecs[7] = '{"rd_top",     0, 4'h0,    32'h0000_1FFC, 32'h0,         32'h5A5A_A5A5, 1'b0, 32'h0000_1FFC};
        vecs[8] = '{"err_above",  1, 4'h0,    32'h0000_2000, 32'h0,         32'h0,          1'b1, 32'h0};
        vecs[9] = '{"err_below",  1, 4'h0,    32'hFFFF_FFFC, 32'h0,         32'h0,          1'b1, 32'h0};

        for (int i = 0; i < 2048; i++) mem[i] = '0;

        // Reset held across clock edges: every output must be zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single-requester vectors.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wd);
            check({vecs[i].name, "_lat"}, r_lat, 3);
            check({vecs[i].name, "_err"}, {31'd0, r_err}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_rd"}, r_rd, vecs[i].exp_rd);
            check({vecs[i].name, "_en_cycles"}, r_en, vecs[i].exp_err ? 0 : 1);
            check({vecs[i].name, "_other_ack"}, r_other, 0);
            check({vecs[i].name, "_other_rd"}, r_ord, 32'd0);
            if (!vecs[i].exp_err) begin
                check({vecs[i].name, "_baddr"}, r_addr, vecs[i].exp_baddr);
                check({vecs[i].name, "_wen"}, {28'd0, r_wen}, {28'd0, vecs[i].we});
                check({vecs[i].name, "_dout"}, r_dout, vecs[i].wd);
            end
        end

        // The last grant was an error grant to requester 1: requester 0 must win next.
        contend("after_err", 0, 2);

        // Move the pointer to requester 1, then reset: contention must restart at 0.
        run_txn(0, 4'h0, 32'h0000_0010, 32'h0);
        check("pre_rst_rd", r_rd, 32'hDEAD_BEEF);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        contend("rr", 0, 4);

        // Reset during CAPTURE of a read: no Ack, outputs cleared at once.
        @(negedge clk);
        req0 = 1'b1; we0 = '0; addr0 = 32'h0000_0020;
        @(posedge clk);          // into ACCESS
        @(posedge clk);          // into CAPTURE
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_ack", {31'd0, ack0}, 32'd0);
        end
        rst = 1'b0;
        wait_ack(0);
        check("reissue_lat", r_lat, 3);
        check("reissue_rd", r_rd, 32'h11BB_3344);
        check("reissue_err", {31'd0, r_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
